// File: rtl/ledbus_rx.sv
// Receive end of a two-wire LED display bus (TM1640-style): sync, start/stop
// detection, byte deserialiser, command decode, 2**ADDR_W x 8 display RAM.
// Optional glitch filter on the synced lines: define LEDBUS_GLITCH_FILTER_EN.
module ledbus_rx #(
  parameter int ADDR_W        = 4,
  parameter int FILTER_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_SCLK,
  input  logic              i_DIN,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_disp_on,
  output logic [2:0]        o_brightness,
  output logic              o_auto_inc,
  output logic              o_busy,
  output logic              o_frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_SKIP} state_t;

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 15 || ADDR_W < 1 || ADDR_W > 8) begin : g_param_check
    $error("ledbus_rx: FILTER_CYCLES must be 1..15 and ADDR_W 1..8");
  end

  logic sclk_s1, sclk_s2, din_s1, din_s2;
  logic sclk_c, din_c;
  logic sclk_h, din_h;
  logic ev_rise, ev_start, ev_stop, ev_din;

  // Sync flops clear to 0 so a reset released mid-frame cannot fake a start:
  // a 0->1 DIN change seen together with SCLK never satisfies the start rule.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      din_s1  <= 1'b0;
      din_s2  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous stage's old value.
      sclk_s1 <= i_SCLK;
      sclk_s2 <= sclk_s1;
      din_s1  <= i_DIN;
      din_s2  <= din_s1;
    end
  end

`ifdef LEDBUS_GLITCH_FILTER_EN
  logic [3:0] sclk_run, din_run;
  logic       sclk_f, din_f;

  // A filtered line follows the synced line only after FILTER_CYCLES differing samples in a row.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_run <= '0;
      din_run  <= '0;
      sclk_f   <= 1'b0;
      din_f    <= 1'b0;
    end else begin
      if (sclk_s2 == sclk_f) begin
        sclk_run <= '0;
      end else if (sclk_run == 4'(FILTER_CYCLES - 1)) begin
        sclk_f   <= sclk_s2;
        sclk_run <= '0;
      end else begin
        sclk_run <= sclk_run + 4'd1;
      end
      if (din_s2 == din_f) begin
        din_run <= '0;
      end else if (din_run == 4'(FILTER_CYCLES - 1)) begin
        din_f   <= din_s2;
        din_run <= '0;
      end else begin
        din_run <= din_run + 4'd1;
      end
    end
  end

  assign sclk_c = sclk_f;
  assign din_c  = din_f;
`else
  assign sclk_c = sclk_s2;
  assign din_c  = din_s2;
`endif

  // History flops plus a registered event stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_h   <= 1'b0;
      din_h    <= 1'b0;
      ev_rise  <= 1'b0;
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
      ev_din   <= 1'b0;
    end else begin
      sclk_h   <= sclk_c;
      din_h    <= din_c;
      ev_rise  <= sclk_c & ~sclk_h;
      ev_start <= sclk_c & sclk_h & din_h & ~din_c;
      ev_stop  <= sclk_c & sclk_h & ~din_h & din_c;
      ev_din   <= din_c;
    end
  end

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [2:0]        rise_cnt;
  logic [7:0]        shreg;
  logic [7:0]        byte_next;
  logic [ADDR_W-1:0] addr;
  logic              ram_we;

  always_comb begin
    // NOTE: default assignment first, so the partial-index write below cannot infer a latch.
    byte_next          = shreg;
    byte_next[bit_cnt] = ev_din;
  end

  assign ram_we = ~RST & ev_rise & ~ev_start & ~ev_stop & (state == S_DATA) & (bit_cnt == 3'd7);

  // Every stop is preceded by its own SCLK rise; rise_cnt holds the bit count
  // from before that rise so a clean stop after a whole byte is not an error.
  always_ff @(posedge CLK) begin
    o_wr_valid  <= 1'b0;
    o_frame_err <= 1'b0;
    if (RST) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      rise_cnt     <= '0;
      shreg        <= '0;
      addr         <= '0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_disp_on    <= 1'b0;
      o_brightness <= '0;
      o_auto_inc   <= 1'b1;
      o_busy       <= 1'b0;
    end else if (ev_start) begin
      state    <= S_CMD;
      bit_cnt  <= '0;
      rise_cnt <= '0;
      o_busy   <= 1'b1;
    end else if (ev_stop) begin
      if (state != S_IDLE) begin
        state    <= S_IDLE;
        bit_cnt  <= '0;
        rise_cnt <= '0;
        o_busy   <= 1'b0;
        if (rise_cnt != 3'd0) o_frame_err <= 1'b1;
      end
    end else if (ev_rise && state != S_IDLE) begin
      shreg    <= byte_next;
      rise_cnt <= bit_cnt;
      bit_cnt  <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        case (state)
          S_CMD: begin
            case (byte_next[7:6])
              2'b01: begin
                o_auto_inc <= ~byte_next[2];
                state      <= S_SKIP;
              end
              2'b10: begin
                o_disp_on    <= byte_next[3];
                o_brightness <= byte_next[2:0];
                state        <= S_SKIP;
              end
              2'b11: begin
                addr  <= byte_next[ADDR_W-1:0];
                state <= S_DATA;
              end
              default: begin
                o_frame_err <= 1'b1;
                state       <= S_SKIP;
              end
            endcase
          end
          S_DATA: begin
            o_wr_valid <= 1'b1;
            o_wr_addr  <= addr;
            o_wr_data  <= byte_next;
            if (o_auto_inc) addr <= addr + ADDR_W'(1);
          end
          S_SKIP:  o_frame_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  logic [7:0] mem [2**ADDR_W];

  // NOTE: the RAM has no reset; display contents survive RST, and resetting arrays blocks RAM inference.
  always_ff @(posedge CLK) begin
    if (ram_we) mem[addr] <= byte_next;
  end

  // A read colliding with a write returns the old contents.
  always_ff @(posedge CLK) begin
    if (RST) o_rd_data <= '0;
    else     o_rd_data <= mem[i_rd_addr];
  end

endmodule
